// File: rtl/pre_if_stage.sv
`default_nettype none
// ============================================================================
// pre_if_stage : pre-fetch stage that owns the fetch PC, picks the next fetch
//                address and issues the I-cache request.
// Revision     : 1.0
// ============================================================================
module pre_if_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000,
   parameter logic [4:0]  EX_ADEL  = 5'h04
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fs_allowin,
   output logic        ps_to_fs_valid,
   output logic [38:0] ps_to_fs_bus,
   input  logic [32:0] BPU_to_ps_bus,
   input  logic        br_flush,
   input  logic [31:0] br_target,
   input  logic        flush,
   input  logic [31:0] flush_target,
   output logic        inst_sram_req,
   output logic [31:0] inst_sram_addr,
   input  logic        icache_addr_ok
);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] pend_target_q;
   logic        ps_valid_q;

   logic        predict_valid;
   logic [31:0] bpu_target;
   logic [31:0] nextpc;
   logic        ps_valid;
   logic        adel;
   logic        fire;

   assign predict_valid = BPU_to_ps_bus[0];
   assign bpu_target    = BPU_to_ps_bus[32:1];

   // Reset forces the reset vector so the bus is defined even before the
   // registers have seen their first reset edge.
   always_comb begin
      nextpc = pc_q + 32'd4;
      if (reset)
         nextpc = RESET_PC;
      else if (flush)
         nextpc = flush_target;
      else if (br_flush)
         nextpc = br_target;
      else if (state_q == HOLD)
         nextpc = pend_target_q;
      else if (predict_valid)
         nextpc = bpu_target;
   end

   assign ps_valid = ps_valid_q & ~reset;
   assign adel     = |nextpc[1:0];
   assign fire     = ps_valid & fs_allowin & (adel | icache_addr_ok);

   assign inst_sram_req  = ps_valid & fs_allowin & ~adel;
   assign inst_sram_addr = nextpc;
   assign ps_to_fs_valid = fire;
   assign ps_to_fs_bus   = {~adel, nextpc, adel, (adel ? EX_ADEL : 5'd0)};

   // A redirect that cannot be issued this cycle is parked in pend_target_q;
   // in HOLD only flush/br_flush may replace it, predictions are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC - 32'd4;
         ps_valid_q    <= 1'b0;
         state_q       <= RUN;
         pend_target_q <= 32'd0;
      end else begin
         ps_valid_q <= 1'b1;
         if (fire) begin
            pc_q          <= nextpc;
            state_q       <= RUN;
            pend_target_q <= 32'd0;
         end else if (state_q == RUN) begin
            if (flush | br_flush | predict_valid) begin
               state_q       <= HOLD;
               pend_target_q <= nextpc;
            end
         end else if (flush | br_flush) begin
            pend_target_q <= nextpc;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/pre_if_stage.md
# pre_if_stage

Pre-fetch (PS) stage of the five-stage MIPS pipeline, directly upstream of the IF stage. It owns the architectural fetch PC and selects the next fetch address from four sources: exception redirect, branch-mispredict redirect, BPU prediction, or sequential PC+4. It issues the I-cache request, flags misaligned fetch addresses as AdEL, and passes `{inst_valid, pc, ex, exctype}` to IF. It buffers any redirect that arrives while the request cannot be issued, so no redirect is ever lost.

## Interface
Parameters:
- `RESET_PC`, default 32'hBFC00000: first fetch address after reset.
- `EX_ADEL`, default 5'h04: ExcCode placed in the bus for a misaligned fetch.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `fs_allowin`  in  1  IF stage can accept a new PS entry this cycle.
- `ps_to_fs_valid`  out  1  PS entry is valid and its request has been accepted this cycle.
- `ps_to_fs_bus`  out  39  `{inst_valid[38], pc[37:6], ex[5], exctype[4:0]}`.
- `BPU_to_ps_bus`  in  33  `{bpu_target[32:1], predict_valid[0]}` from IF.
- `br_flush`  in  1  ID detected a mispredict.
- `br_target`  in  32  corrected PC from ID.
- `flush`  in  1  exception or ERET redirect from WB.
- `flush_target`  in  32  exception vector or EPC.
- `inst_sram_req`  out  1  I-cache request strobe.
- `inst_sram_addr`  out  32  request address; always equals `nextpc`.
- `icache_addr_ok`  in  1  I-cache accepted the request this cycle.

## Operation
- **PC register `pc_r`**: resets to RESET_PC-4. `nextpc` selects one source, in priority order:
  1. `flush` → `flush_target`
  2. `br_flush` → `br_target`
  3. pending redirect → `pend_target`
  4. `predict_valid` → `bpu_target`
  5. otherwise → `pc_r+4`
- **Arithmetic**: 32-bit wrap; 32'hFFFFFFFC+4 = 0.
- **Address error**: `adel = |nextpc[1:0]`.
- **Request and fire**:
  - `inst_sram_req = ps_valid & fs_allowin & ~adel`.
  - `fire = ps_valid & fs_allowin & (adel | icache_addr_ok)`.
  - `ps_to_fs_valid = fire`.
- **Bus contents**:
  - `pc = nextpc`.
  - `ex = adel`.
  - `exctype = adel ? EX_ADEL : 0`.
  - `inst_valid = ~adel`.
- **On fire**: `pc_r <= nextpc`; any pending redirect is cleared.
- **`ps_valid`**: 0 during reset, 1 from the cycle after reset deasserts, and stays 1 thereafter. PS is a virtual stage that is always ready to fetch.
- **Redirect FSM** (`RUN`, `HOLD`):
  - RUN → HOLD when `(flush | br_flush | predict_valid) & ~fire`. Latch `pend_target` = the selected redirect target.
  - HOLD → RUN on fire.
  - In HOLD, a new `flush` or `br_flush` overwrites `pend_target`. `predict_valid` in HOLD is ignored.
  - A redirect that fires in the same cycle does not enter HOLD.
- **Simultaneous events**:
  - `flush` and `br_flush` together: `flush` wins and is the one latched.
  - `br_flush` and `predict_valid` together: `br_flush` wins.
- **Reset mid-operation**: `pc_r`, `ps_valid`, the FSM (→RUN) and `pend_target` (→0) all reinitialize in the same edge. No request is issued while reset is high.

## Timing
- Outputs during reset and in the first reset cycle:
  - `ps_to_fs_valid` = 0
  - `inst_sram_req` = 0
  - `ps_to_fs_bus.pc` = RESET_PC
- First request is issued in the cycle after reset deasserts, provided `fs_allowin`=1.
- Requests are combinational from the inputs in the same cycle. There is no extra latency: `inst_sram_addr` reflects a `flush` or `br_flush` in the cycle it is asserted.
- While `fs_allowin`=0 or `icache_addr_ok`=0:
  - `inst_sram_addr` holds its value unless a higher-priority redirect arrives.
  - `pc_r` does not change.
- Throughput: one fire per cycle when `fs_allowin` and `icache_addr_ok` are held high.
- A redirect seen at cycle N takes effect on the first fire at or after N. It never takes effect later than that.

## Test plan
- **Reset and sequential fetch**: release reset, hold `fs_allowin`=`icache_addr_ok`=1 → fires at 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles, `inst_valid`=1, `ex`=0.
- **Prediction**: `predict_valid`=1 with `bpu_target`=0xBFC00100 while `pc_r`=0xBFC00004 → next fire at 0xBFC00100, then 0xBFC00104.
- **Redirect under stall**: `icache_addr_ok`=0 and pulse `br_flush` with `br_target`=0x80001000 for one cycle; raise `addr_ok` three cycles later → first fire at 0x80001000 and no fire at any other address.
- **Priority**: `flush` (0xBFC00380) and `br_flush` (0x80002000) in the same cycle → fire at 0xBFC00380. In HOLD, a later `flush` replaces a pending `br_target`.
- **AdEL**: `br_flush` with target 0x80000002 → `inst_sram_req`=0, `ps_to_fs_valid`=1 when `fs_allowin`=1, `ex`=1, `exctype`=5'h04, `inst_valid`=0, `pc`=0x80000002.
- **Reset mid-HOLD**: assert reset while in HOLD with a pending target → after reset, the first fire is at RESET_PC and the pending target is discarded.
